// File: rtl/reg_file_rw.sv
// ---------------------------------------------------------------------------
// reg_file_rw : Thumb register file
//
// Holds R0-R14. R15 is not stored: reads of R15 return the word-aligned
// Thumb PC view of pc_i, and writes to R15 are turned into a one-cycle
// branch request (pc_wr_o / pc_wr_data_o) for the fetch stage.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   : write-through bypass; a read that matches an enabled write
//               address (not R15) returns that same-cycle write data,
//               port A ahead of port B.
//   undefined : reads return the value committed at the previous edge.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   pc_i           address of the instruction in decode
//   rd_addr_1_i .. rd_addr_3_i / rd_data_1_o .. rd_data_3_o
//                  three independent combinational read ports
//   wr_en_a_i, wr_addr_a_i, wr_data_a_i
//                  write port A (result / load writeback), has priority
//   wr_en_b_i, wr_addr_b_i, wr_data_b_i
//                  write port B (base / SP update)
//   pc_wr_o        registered pulse: an R15 write was accepted last cycle
//   pc_wr_data_o   registered R15 write target with bit 0 cleared
// ---------------------------------------------------------------------------
module reg_file_rw #(
    parameter int                   ADDR_WIDTH = 4,
    parameter int                   DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] SP_RESET  = 32'h0000_1000,
    parameter int                   SP_REG_NUM = 13,
    parameter int                   LR_REG_NUM = 14,
    parameter int                   PC_REG_NUM = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_3_i,
    output logic [DATA_WIDTH-1:0] rd_data_1_o,
    output logic [DATA_WIDTH-1:0] rd_data_2_o,
    output logic [DATA_WIDTH-1:0] rd_data_3_o,
    input  logic                  wr_en_a_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a_i,
    input  logic [DATA_WIDTH-1:0] wr_data_a_i,
    input  logic                  wr_en_b_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b_i,
    input  logic [DATA_WIDTH-1:0] wr_data_b_i,
    output logic                  pc_wr_o,
    output logic [DATA_WIDTH-1:0] pc_wr_data_o
);

    // Storage covers R0 up to and including the link register.
    localparam int NUM_STORED = LR_REG_NUM + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(PC_REG_NUM);

    logic [DATA_WIDTH-1:0] regs [0:NUM_STORED-1];

    logic                  pc_hit_a;
    logic                  pc_hit_b;
    logic [DATA_WIDTH-1:0] pc_view;

    assign pc_hit_a = wr_en_a_i && (wr_addr_a_i == PC_ADDR);
    assign pc_hit_b = wr_en_b_i && (wr_addr_b_i == PC_ADDR);

    // Thumb PC as seen by an instruction: current address + 4, word aligned.
    assign pc_view = (pc_i + DATA_WIDTH'(4)) & ~DATA_WIDTH'(3);

    // ------------------------------------------------------------------
    // Register storage. Port A is checked first so a same-address
    // collision keeps A's data and silently drops B.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_STORED; i++) begin
                regs[i] <= (i == SP_REG_NUM) ? SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NUM_STORED; i++) begin
                if (wr_en_a_i && (wr_addr_a_i == ADDR_WIDTH'(i))) begin
                    regs[i] <= wr_data_a_i;
                end else if (wr_en_b_i && (wr_addr_b_i == ADDR_WIDTH'(i))) begin
                    regs[i] <= wr_data_b_i;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // R15 write request. pc_wr_o is rebuilt every cycle, so it is a
    // single-cycle pulse. The target holds its last value between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_wr_o      <= 1'b0;
            pc_wr_data_o <= '0;
        end else begin
            pc_wr_o <= pc_hit_a || pc_hit_b;
            if (pc_hit_a) begin
                pc_wr_data_o <= wr_data_a_i & ~DATA_WIDTH'(1);
            end else if (pc_hit_b) begin
                pc_wr_data_o <= wr_data_b_i & ~DATA_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path shared by all three ports. The R15 test comes first so
    // the storage array is only indexed with in-range addresses.
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr == PC_ADDR) begin
            value = pc_view;
`ifdef REG_FILE_BYPASS_EN
        end else if (wr_en_a_i && (wr_addr_a_i == addr)) begin
            value = wr_data_a_i;
        end else if (wr_en_b_i && (wr_addr_b_i == addr)) begin
            value = wr_data_b_i;
`endif
        end else begin
            value = regs[addr];
        end
        return value;
    endfunction

    always_comb begin
        rd_data_1_o = read_reg(rd_addr_1_i);
        rd_data_2_o = read_reg(rd_addr_2_i);
        rd_data_3_o = read_reg(rd_addr_3_i);
    end

endmodule

// File: tb/tb_reg_file_rw.sv
// ---------------------------------------------------------------------------
// tb_reg_file_rw : directed self-checking bench for reg_file_rw.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// input change (combinational reads) or 1 ns after the rising edge
// (registered outputs and committed writes).
// ---------------------------------------------------------------------------
module tb_reg_file_rw;

    localparam int          AW       = 4;
    localparam int          DW       = 32;
    localparam logic [31:0] SP_RESET = 32'h0000_1000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] pc;
    logic [AW-1:0] rd_addr_1, rd_addr_2, rd_addr_3;
    logic [DW-1:0] rd_data_1, rd_data_2, rd_data_3;
    logic          wr_en_a, wr_en_b;
    logic [AW-1:0] wr_addr_a, wr_addr_b;
    logic [DW-1:0] wr_data_a, wr_data_b;
    logic          pc_wr;
    logic [DW-1:0] pc_wr_data;

    int passed = 0;
    int total  = 0;

    reg_file_rw dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pc_i         (pc),
        .rd_addr_1_i  (rd_addr_1),
        .rd_addr_2_i  (rd_addr_2),
        .rd_addr_3_i  (rd_addr_3),
        .rd_data_1_o  (rd_data_1),
        .rd_data_2_o  (rd_data_2),
        .rd_data_3_o  (rd_data_3),
        .wr_en_a_i    (wr_en_a),
        .wr_addr_a_i  (wr_addr_a),
        .wr_data_a_i  (wr_data_a),
        .wr_en_b_i    (wr_en_b),
        .wr_addr_b_i  (wr_addr_b),
        .wr_data_b_i  (wr_data_b),
        .pc_wr_o      (pc_wr),
        .pc_wr_data_o (pc_wr_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        rd_addr_1 = a1;
        rd_addr_2 = a2;
        rd_addr_3 = a3;
    endtask

    task automatic idle_writes();
        wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    endtask

    // Present writes on the falling edge, commit on the next rising edge,
    // then drop the enables 1 ns later.
    task automatic do_write(input logic ea, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                            input logic eb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        @(negedge clk);
        wr_en_a = ea; wr_addr_a = aa; wr_data_a = da;
        wr_en_b = eb; wr_addr_b = ab; wr_data_b = db;
        @(posedge clk);
        #1;
        idle_writes();
    endtask

    task automatic read_all3(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        set_reads(a, a, a);
        #1;
        check({tag, "_p1"}, rd_data_1, exp);
        check({tag, "_p2"}, rd_data_2, exp);
        check({tag, "_p3"}, rd_data_3, exp);
    endtask

    logic [DW-1:0] bypass_exp_a;
    logic [DW-1:0] bypass_exp_b;

    initial begin
        pc = 32'h100;
        set_reads('0, '0, '0);
        idle_writes();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            set_reads(AW'(a), AW'(15 - a), AW'(a));
            #1;
            check($sformatf("reset_r%0d", a), rd_data_1,
                  (a == 13) ? SP_RESET : (a == 15) ? 32'h104 : 32'h0);
            check($sformatf("reset_rev_r%0d", 15 - a), rd_data_2,
                  ((15 - a) == 13) ? SP_RESET : ((15 - a) == 15) ? 32'h104 : 32'h0);
        end
        check("reset_pc_wr", {31'b0, pc_wr}, 32'h0);
        check("reset_pc_wr_data", pc_wr_data, 32'h0);

        // ---- basic write A then read on all ports ----
        do_write(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'h0);
        read_all3("basic_r3", 4'd3, 32'hDEAD_BEEF);

        // ---- port B alone, and A/B to different registers together ----
        do_write(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h0000_0077);
        read_all3("portb_r7", 4'd7, 32'h77);
        do_write(1'b1, 4'd1, 32'h1111_0001, 1'b1, 4'd2, 32'h2222_0002);
        set_reads(4'd1, 4'd2, 4'd3);
        #1;
        check("dual_r1", rd_data_1, 32'h1111_0001);
        check("dual_r2", rd_data_2, 32'h2222_0002);
        check("dual_r3_kept", rd_data_3, 32'hDEAD_BEEF);

        // ---- A and B collide on R13: A wins ----
        do_write(1'b1, 4'd13, 32'h10, 1'b1, 4'd13, 32'h20);
        read_all3("conflict_r13", 4'd13, 32'h10);

        // ---- LR write via B ----
        do_write(1'b0, 4'd0, 32'h0, 1'b1, 4'd14, 32'hCAFE_0E0E);
        read_all3("lr_r14", 4'd14, 32'hCAFE_0E0E);

        // ---- B writes R15: one-cycle pulse, bit 0 cleared, no storage change ----
        do_write(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h0000_0203);
        check("pcw_b_pulse", {31'b0, pc_wr}, 32'h1);
        check("pcw_b_data", pc_wr_data, 32'h202);
        set_reads(4'd15, 4'd13, 4'd14);
        #1;
        check("pcw_b_r15_view", rd_data_1, 32'h104);
        check("pcw_b_r13_kept", rd_data_2, 32'h10);
        check("pcw_b_r14_kept", rd_data_3, 32'hCAFE_0E0E);
        @(posedge clk);
        #1;
        check("pcw_b_pulse_end", {31'b0, pc_wr}, 32'h0);

        // ---- both ports write R15: A's data used ----
        do_write(1'b1, 4'd15, 32'h0000_0301, 1'b1, 4'd15, 32'h0000_0405);
        check("pcw_ab_pulse", {31'b0, pc_wr}, 32'h1);
        check("pcw_ab_data", pc_wr_data, 32'h300);
        @(posedge clk);
        #1;
        check("pcw_ab_pulse_end", {31'b0, pc_wr}, 32'h0);

        // ---- R15 read view: alignment and wrap ----
        pc = 32'h102;
        set_reads(4'd15, 4'd15, 4'd15);
        #1;
        check("pcview_102", rd_data_1, 32'h104);
        pc = 32'h7;
        #1;
        check("pcview_7", rd_data_2, 32'h8);
        pc = 32'hFFFF_FFFE;
        #1;
        check("pcview_wrap", rd_data_3, 32'h0);
        pc = 32'h100;

        // ---- same-cycle write/read of R5 (A) and R6 (B) ----
`ifdef REG_FILE_BYPASS_EN
        bypass_exp_a = 32'h55;
        bypass_exp_b = 32'h66;
`else
        bypass_exp_a = 32'h0;
        bypass_exp_b = 32'h0;
`endif
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 32'h55;
        wr_en_b = 1'b1; wr_addr_b = 4'd6; wr_data_b = 32'h66;
        set_reads(4'd5, 4'd6, 4'd15);
        #1;
        check("bypass_a_r5", rd_data_1, bypass_exp_a);
        check("bypass_b_r6", rd_data_2, bypass_exp_b);
        check("bypass_r15_view", rd_data_3, 32'h104);
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        check("after_bypass_r5", rd_data_1, 32'h55);
        check("after_bypass_r6", rd_data_2, 32'h66);

        // ---- asynchronous reset between edges ----
        do_write(1'b1, 4'd2, 32'h0000_2222, 1'b1, 4'd15, 32'h0000_0501);
        set_reads(4'd2, 4'd13, 4'd5);
        #1;
        check("pre_rst_r2", rd_data_1, 32'h2222);
        check("pre_rst_pc_wr", {31'b0, pc_wr}, 32'h1);
        check("pre_rst_pc_data", pc_wr_data, 32'h500);
        rst_n = 1'b0;
        #1;
        check("async_rst_r2", rd_data_1, 32'h0);
        check("async_rst_r13", rd_data_2, SP_RESET);
        check("async_rst_r5", rd_data_3, 32'h0);
        check("async_rst_pc_wr", {31'b0, pc_wr}, 32'h0);
        check("async_rst_pc_data", pc_wr_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_r2", rd_data_1, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
